// File: rtl/hero_write_packer.sv
// Packs hero-bus write beats into BEATS_PER_WORD-wide words and queues them
// in a show-ahead FIFO whose occupancy backpressures the hero source.

module hero_pack_slot #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt
);
  // nxt is the slot value as it will be pushed when this beat closes the word
  assign nxt = wr ? din : q;

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (wr)    q <= din;
  end
endmodule

module hero_write_packer #(
  parameter int HERO_WIDTH     = 36,
  parameter int BEATS_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = $clog2(BEATS_PER_WORD + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [1:0]                           in_cycle_type,
  input  logic [HERO_WIDTH-1:0]                in_wdat,
  input  logic                                 in_clk_en,
  output logic                                 in_ready,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [HERO_WIDTH*BEATS_PER_WORD-1:0] out_data,
  output logic [CNT_WIDTH-1:0]                 out_beats,
  output logic                                 out_last,
  output logic                                 err_illegal,
  output logic [15:0]                          words_pushed
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]          DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] BEATS_C  = CNT_WIDTH'(BEATS_PER_WORD);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BEATS_PER_WORD - 1);
  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;
  localparam logic [1:0] CT_ILL   = 2'd3;

  typedef enum logic {EMPTY, ACCUM} state_e;

  typedef struct packed {
    logic [BEATS_PER_WORD-1:0][HERO_WIDTH-1:0] data;
    logic [CNT_WIDTH-1:0]                      beats;
    logic                                      last;
  } word_t;

  state_e                                    state_q, state_d;
  logic [CNT_WIDTH-1:0]                      idx_q, idx_d;
  logic [BEATS_PER_WORD-1:0][HERO_WIDTH-1:0] asm_q, word_nxt;
  logic [BEATS_PER_WORD-1:0]                 slot_hit;

  logic accept, beat_valid, beat_done, beat_ill, beat_wr;
  logic push, pop, push_last;
  logic [CNT_WIDTH-1:0] push_beats;
  word_t push_word, head;

  word_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Input qualification; illegal beats are swallowed without touching assembly
  assign accept     = in_ready & in_clk_en & (in_cycle_type != CT_IDLE);
  assign beat_valid = accept & (in_cycle_type == CT_VALID);
  assign beat_done  = accept & (in_cycle_type == CT_DONE);
  assign beat_ill   = accept & (in_cycle_type == CT_ILL);
  assign beat_wr    = beat_valid | beat_done;

  for (genvar k = 0; k < BEATS_PER_WORD; k++) begin : g_slot
    assign slot_hit[k] = beat_wr & (idx_q == CNT_WIDTH'(k));
    hero_pack_slot #(.W(HERO_WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .clr (push),
      .wr  (slot_hit[k]),
      .din (in_wdat),
      .q   (asm_q[k]),
      .nxt (word_nxt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    push       = 1'b0;
    push_last  = 1'b0;
    push_beats = '0;
    case (state_q)
      EMPTY: begin
        if (beat_done) begin
          push       = 1'b1;
          push_last  = 1'b1;
          push_beats = CNT_WIDTH'(1);
        end else if (beat_valid) begin
          if (BEATS_PER_WORD == 1) begin
            push       = 1'b1;
            push_beats = CNT_WIDTH'(1);
          end else begin
            state_d = ACCUM;
            idx_d   = CNT_WIDTH'(1);
          end
        end
      end
      ACCUM: begin
        if (beat_done) begin
          push       = 1'b1;
          push_last  = 1'b1;
          push_beats = idx_q + CNT_WIDTH'(1);
          state_d    = EMPTY;
          idx_d      = '0;
        end else if (beat_valid) begin
          if (idx_q == LAST_IDX) begin
            push       = 1'b1;
            push_beats = BEATS_C;
            state_d    = EMPTY;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + CNT_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    push_word.data  = word_nxt;
    push_word.beats = push_beats;
    push_word.last  = push_last;
  end

  // Output FIFO; pushes only happen when in_ready, so it can never overflow
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Gate on valid so uninitialised storage never shows on the outputs
  assign out_data  = out_valid ? head.data  : '0;
  assign out_beats = out_valid ? head.beats : '0;
  assign out_last  = out_valid & head.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_illegal  <= 1'b0;
      words_pushed <= '0;
    end else begin
      if (beat_ill) err_illegal  <= 1'b1;
      if (push)     words_pushed <= words_pushed + 16'd1;
    end
  end
endmodule

// File: doc/hero_write_packer.md
Name: hero_write_packer

Overview:
- Accepts hero write beats (cycle type, data, clock enable) on the hero bus and packs them into wide words of BEATS_PER_WORD beats.
- A DONE beat closes a partial word early and marks it as the last word of the transaction.
- Packed words are buffered in an output FIFO with valid/ready. The FIFO drives in_ready back to the hero source, which the plain valid-only hero bus cannot do.
- Sits between a hero bus producer and wide consumers such as SRAM write ports or NoC packetisers.

Parameters:
- HERO_WIDTH, 36, width of one hero data beat.
- BEATS_PER_WORD, 4, beats packed per output word; legal range 1..16.
- FIFO_DEPTH, 4, output FIFO entries; legal range 2..32, power of two.
- CNT_WIDTH, clog2(BEATS_PER_WORD+1), derived; width of beat-count fields.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_cycle_type  in  2  CYCLE_TYPE_E: 0 IDLE, 1 VALID, 2 DONE; 3 is illegal.
- in_wdat  in  HERO_WIDTH  beat data.
- in_clk_en  in  1  beat qualifier; a beat is ignored when 0.
- in_ready  out  1  packer can accept a beat this cycle.
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  HERO_WIDTH*BEATS_PER_WORD  packed word; beat k is at [k*HERO_WIDTH +: HERO_WIDTH].
- out_beats  out  CNT_WIDTH  number of valid beats in the word, 1..BEATS_PER_WORD.
- out_last  out  1  word was closed by a DONE beat.
- err_illegal  out  1  sticky; set by an accepted beat with cycle type 3.
- words_pushed  out  16  wrapping count of words written into the FIFO.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_beats=0, out_last=0.
  - err_illegal=0, words_pushed=0.
  - in_ready=1 starting the first cycle after reset deasserts.
  - Assembly register and beat index cleared.
- Reset mid-operation discards the partial word and all FIFO contents; nothing is emitted afterwards.
- Beat acceptance:
  - accept = in_ready & in_clk_en & (in_cycle_type != IDLE).
  - The source must hold a beat while in_ready=0.
  - Beats with in_clk_en=0 or type IDLE never change state, even when in_ready=0.
- Illegal type (3): when accepted, the beat is dropped and err_illegal is set. Assembly state is unchanged. err_illegal clears only on rst.
- FSM states:
  - EMPTY: beat index 0, nothing held.
  - ACCUM: 1..BEATS_PER_WORD-1 beats held.
- Transitions:
  - EMPTY + VALID: store beat at slot 0. Go to ACCUM, or push immediately if BEATS_PER_WORD=1 (out_last=0).
  - ACCUM + VALID:
    - Store beat at slot idx.
    - If idx+1 == BEATS_PER_WORD, push with out_beats=BEATS_PER_WORD, out_last=0, then go to EMPTY.
    - Otherwise stay in ACCUM with idx+1.
  - EMPTY or ACCUM + DONE: store beat at slot idx, push with out_beats=idx+1, out_last=1, then go to EMPTY.
- Unused slots of a pushed word are zero. A fresh word always starts zero-filled.
- Push timing:
  - The word is written into the FIFO on the edge that accepts the closing beat.
  - out_valid rises the next cycle at the earliest, so input-to-output latency is 1 cycle from the closing beat.
- FIFO:
  - Show-ahead; out_* reflect the head entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are legal; occupancy is unchanged and order is preserved.
  - out_data/out_beats/out_last are stable while out_valid=1 and out_ready=0.
- Backpressure:
  - in_ready = (occupancy < FIFO_DEPTH), computed from registered occupancy only; there is no combinational path from out_ready.
  - When full, in_ready=0 even if the next beat would not close a word.
- words_pushed increments by 1 per push and wraps 0xFFFF to 0.
- A DONE beat with no preceding VALID beats is legal: one-beat word, out_last=1.

Test Plan:
- Reset, then VALID A0,A1,A2 and DONE A3 (data 0x1..0x4) with out_ready=1 -> one word, out_data=0x4_00000000_3_00000000_2_00000000_1 (36-bit slots), out_beats=4, out_last=1, words_pushed=1.
- VALID x5, then DONE, beat data 0x10..0x15 -> word0 slots 0x10..0x13, beats=4, last=0. Word1 slots 0x14,0x15 with upper 72 bits zero, beats=2, last=1.
- out_ready=0, stream 20 VALID beats -> 4 words queued, in_ready=0 after the 16th beat is accepted, beats 17..20 held. Raise out_ready -> words drain in order, no loss, words 5 complete.
- Accepted beat with in_cycle_type=3 mid-word between VALID 0x7 and DONE 0x8 -> err_illegal=1 and stays 1. Word is 0x7,0x8 with beats=2, last=1.
- in_clk_en=0 with type VALID, and type IDLE with clk_en=1, each for 10 cycles -> no state change, words_pushed unchanged.
- Two VALID beats, then rst for 1 cycle, then DONE 0x9 -> single word, slot0=0x9, beats=1, last=1, words_pushed=1. The pre-reset beats never appear.
